// File: rtl/random_spawn_queue.sv
// Spawn-position producer: requests 4-bit random values, rejects immediate repeats
// with bounded retries, maps them to screen X and queues them in a show-ahead FIFO.
module random_spawn_queue #(
   parameter int         DEPTH     = 4,
   parameter logic [9:0] COL_W     = 10'd40,
   parameter logic [9:0] X_OFFSET  = 10'd0,
   parameter int         RAND_WAIT = 2,
   parameter int         MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [3:0] rand_in,
   output logic       rand_req,
   output logic [9:0] spawn_x,
   output logic       spawn_valid,
   input  logic       spawn_pop,
   output logic [3:0] count,
   output logic       full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, PUSH} state_t;

   state_t                     state_reg, state_next;
   logic [3:0]                 wait_reg;
   logic [3:0]                 sample_reg;
   logic [3:0]                 last_val_reg;
   logic [3:0]                 retry_reg;
   logic                       has_last_reg;
   logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
   logic [3:0]                 count_reg;
   logic [DEPTH-1:0][9:0]      mem_bus;
   logic                       push, pop, repeat_hit;
   logic [9:0]                 push_x;

   assign repeat_hit = has_last_reg && (sample_reg == last_val_reg)
                       && (retry_reg < 4'(MAX_RETRY));
   assign push       = (state_reg == PUSH);
   assign pop        = spawn_pop && (count_reg != 4'd0);
   // Arithmetic stays 10 bits wide, so off-screen results wrap modulo 1024.
   assign push_x     = 10'(sample_reg) * COL_W + X_OFFSET;

   assign spawn_x     = mem_bus[rd_ptr_reg];
   assign spawn_valid = (count_reg != 4'd0);
   assign count       = count_reg;
   assign full        = (count_reg == 4'(DEPTH));

   always_comb begin
      state_next = state_reg;
      rand_req   = 1'b0;
      case (state_reg)
         IDLE:  if (enable && !full) state_next = REQ;
         REQ: begin
            rand_req   = 1'b1;
            state_next = WAIT;
         end
         WAIT:  if (wait_reg == 4'd0) state_next = CHECK;
         CHECK: state_next = repeat_hit ? REQ : PUSH;
         PUSH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         wait_reg     <= 4'd0;
         sample_reg   <= 4'd0;
         last_val_reg <= 4'd0;
         retry_reg    <= 4'd0;
         has_last_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= 4'd0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            REQ:  wait_reg <= 4'(RAND_WAIT - 1);
            WAIT: begin
               if (wait_reg == 4'd0) sample_reg <= rand_in;
               else                  wait_reg   <= wait_reg - 4'd1;
            end
            CHECK: if (repeat_hit) retry_reg <= retry_reg + 4'd1;
            PUSH: begin
               last_val_reg <= sample_reg;
               has_last_reg <= 1'b1;
               retry_reg    <= 4'd0;
            end
            default: ;
         endcase
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + {3'd0, push} - {3'd0, pop};
      end
   end

   // One register per FIFO slot so every entry clears on reset.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic [9:0] entry_reg;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)                                 entry_reg <= 10'd0;
         else if (push && wr_ptr_reg == PTR_W'(gi))    entry_reg <= push_x;
      end
      assign mem_bus[gi] = entry_reg;
   end

endmodule

// File: tb/tb_random_spawn_queue.sv
// Bench for random_spawn_queue: vector table, directed corner sequences and a
// randomized run against a schedule/queue reference model.
module tb_random_spawn_queue;

   localparam int RW  = 2;
   localparam int DEP = 4;
   localparam int MR  = 3;

   logic       clk = 1'b0, reset_n = 1'b0;
   logic       enable = 1'b0, spawn_pop = 1'b0;
   logic [3:0] rand_in = 4'd0;
   logic       rand_req, spawn_valid, full;
   logic [9:0] spawn_x;
   logic [3:0] count;

   logic       enable2 = 1'b0, pop2 = 1'b0;
   logic [3:0] rand2 = 4'd0;
   logic       req2, valid2, full2;
   logic [9:0] x2;
   logic [3:0] count2;

   random_spawn_queue dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .rand_in(rand_in),
      .rand_req(rand_req), .spawn_x(spawn_x), .spawn_valid(spawn_valid),
      .spawn_pop(spawn_pop), .count(count), .full(full));

   random_spawn_queue #(.X_OFFSET(10'd1000)) dut_off (
      .clk(clk), .reset_n(reset_n), .enable(enable2), .rand_in(rand2),
      .rand_req(req2), .spawn_x(x2), .spawn_valid(valid2),
      .spawn_pop(pop2), .count(count2), .full(full2));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // Reference model: FIFO contents as a queue, sequence progress as event cycles.
   logic [9:0] q[$];
   int         cyc, next_req, sample_at, push_at, retry, nreq;
   bit         busy, has_last;
   logic [3:0] last_v, samp_v;

   function automatic logic [9:0] xof(input int v, input int off);
      return 10'((v * 40 + off) % 1024);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      q.delete();
      busy = 0; has_last = 0; last_v = 4'd0; samp_v = 4'd0;
      next_req = -1; sample_at = -1; push_at = -1; retry = 0; cyc = 0; nreq = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; enable = 1'b0; spawn_pop = 1'b0; enable2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // Called at a falling edge: compare this cycle, drive inputs, advance model.
   task automatic step(input logic en, input logic [3:0] rv, input logic pop);
      bit do_push;
      chk("valid", int'(spawn_valid), int'(q.size() != 0));
      chk("count", int'(count), q.size());
      chk("full", int'(full), int'(q.size() == DEP));
      if (q.size() != 0) chk("spawn_x", int'(spawn_x), int'(q[0]));
      chk("rand_req", int'(rand_req), int'(cyc == next_req));
      if (rand_req) nreq++;
      enable = en; rand_in = rv; spawn_pop = pop;
      do_push = 0;
      if (!busy && en && q.size() < DEP) begin
         busy = 1; next_req = cyc + 1; sample_at = cyc + 1 + RW; push_at = -1;
      end
      if (busy && cyc == sample_at) begin
         samp_v = rv;
         if (has_last && rv == last_v && retry < MR) begin
            retry++; next_req = cyc + 2; sample_at = cyc + 2 + RW;
         end else begin
            push_at = cyc + 2;
         end
      end
      if (busy && cyc == push_at) begin
         do_push = 1; last_v = samp_v; has_last = 1; retry = 0; busy = 0;
      end
      if (pop && q.size() != 0) void'(q.pop_front());
      if (do_push) q.push_back(xof(int'(samp_v), 0));
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0] val;
      logic [9:0] exp_x;
      int         exp_lat;
   } vec_t;

   vec_t tbl[6];
   int   lat;
   logic [9:0] xseen;

   initial begin
      tbl[0] = '{4'd5,  10'd200, 6};
      tbl[1] = '{4'd0,  10'd0,   6};
      tbl[2] = '{4'd15, 10'd600, 6};
      tbl[3] = '{4'd9,  10'd360, 6};
      tbl[4] = '{4'd1,  10'd40,  6};
      tbl[5] = '{4'd12, 10'd480, 6};

      do_reset();
      chk("reset_valid", int'(spawn_valid), 0);
      chk("reset_count", int'(count), 0);
      chk("reset_x", int'(spawn_x), 0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         lat = -1; xseen = 10'd0;
         for (int c = 0; c < 20; c++) begin
            if (spawn_valid && lat < 0) begin lat = c; xseen = spawn_x; end
            step(c == 0, tbl[i].val, 1'b0);
         end
         chk("latency", lat, tbl[i].exp_lat);
         chk("vec_x", int'(xseen), int'(tbl[i].exp_x));
         $display("vector %0d: rand=%0d x=%0d latency=%0d", i, tbl[i].val, xseen, lat);
      end

      // Held repeat: three re-requests, then the repeat is accepted.
      do_reset();
      for (int c = 0; c < 32; c++) step(c == 0 || c == 6, 4'd7, 1'b0);
      chk("repeat_reqs", nreq, 5);
      chk("repeat_count", int'(count), 2);
      step(1'b0, 4'd7, 1'b1);
      chk("repeat_second_x", int'(spawn_x), 280);
      $display("repeat held: requests=%0d count=%0d", nreq, count);

      // Repeat once, then a fresh value.
      do_reset();
      for (int c = 0; c < 24; c++) step(c == 0 || c == 6, (c <= 10) ? 4'd7 : 4'd9, 1'b0);
      chk("retry1_reqs", nreq, 3);
      chk("retry1_count", int'(count), 2);
      step(1'b0, 4'd0, 1'b1);
      chk("retry1_x", int'(spawn_x), 360);
      $display("repeat once: requests=%0d head=%0d", nreq, spawn_x);

      // Fill to full, then one pop releases a new request.
      do_reset();
      for (int c = 0; c < 30; c++) step(1'b1, 4'(1 + c / 6), 1'b0);
      chk("fill_count", int'(count), 4);
      chk("fill_full", int'(full), 1);
      chk("fill_x", int'(spawn_x), 40);
      chk("fill_reqs", nreq, 4);
      step(1'b1, 4'd9, 1'b1);
      chk("fill_pop_x", int'(spawn_x), 80);
      chk("fill_pop_count", int'(count), 3);
      for (int c = 0; c < 3; c++) step(1'b1, 4'd9, 1'b0);
      chk("fill_new_req", nreq, 5);
      $display("fill: full reached, requests after pop=%0d", nreq);

      // Push and pop in the same cycle, then pops on empty.
      do_reset();
      for (int c = 0; c < 17; c++) step(c <= 12, 4'(1 + c / 6), 1'b0);
      chk("pp_count_before", int'(count), 2);
      step(1'b0, 4'd0, 1'b1);
      chk("pp_count_after", int'(count), 2);
      chk("pp_head", int'(spawn_x), 80);
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b1);
      chk("pp_empty", int'(count), 0);
      step(1'b0, 4'd0, 1'b1);
      chk("pp_pop_empty", int'(count), 0);
      chk("pp_pop_empty_valid", int'(spawn_valid), 0);
      $display("push/pop same cycle: count=%0d", count);

      // Offset overflow wraps modulo 1024.
      @(negedge clk);
      enable2 = 1'b1; rand2 = 4'd15;
      @(negedge clk);
      enable2 = 1'b0;
      repeat (8) @(negedge clk);
      chk("overflow_x", int'(x2), 576);
      chk("overflow_valid", int'(valid2), 1);
      $display("overflow: x=%0d", x2);

      // Asynchronous reset while waiting on the generator.
      do_reset();
      for (int c = 0; c < 9; c++) step(c == 0 || c == 6, 4'd5, 1'b0);
      chk("pre_reset_x", int'(spawn_x), 200);
      reset_n = 1'b0;
      #1;
      chk("async_req", int'(rand_req), 0);
      chk("async_valid", int'(spawn_valid), 0);
      chk("async_count", int'(count), 0);
      chk("async_full", int'(full), 0);
      chk("async_x", int'(spawn_x), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int c = 0; c < 5; c++) step(1'b0, 4'd0, 1'b0);
      chk("post_reset_idle", nreq, 0);
      for (int c = 0; c < 8; c++) step(c == 0, 4'd0, 1'b0);
      chk("post_reset_x", int'(spawn_x), 0);
      chk("post_reset_count", int'(count), 1);
      chk("post_reset_reqs", nreq, 1);
      $display("reset in wait: count=%0d requests=%0d", count, nreq);

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 800; c++)
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom_range(0, 9) < 3);
      $display("random: 800 cycles, requests=%0d", nreq);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
